// File: rtl/op_tx_scheduler_pkg.sv
// Shared definitions for the operation transmit scheduler: FSM encodings and
// operation indices used by the menu FSM to address requesters.
package op_tx_scheduler_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } sched_state_e;

   localparam int unsigned OP_ADD    = 0;
   localparam int unsigned OP_SCALAR = 1;
   localparam int unsigned OP_TRANS  = 2;
   localparam int unsigned OP_MUL    = 3;

endpackage

// File: rtl/op_tx_scheduler_if.sv
// Bundle of the scheduler's request/printer/UART signals. The master modport is
// the environment (menu FSM, printers, UART); the slave modport is the scheduler.
interface op_tx_scheduler_if #(
   parameter int unsigned NUM_REQ = 4
);

   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ-1:0]   op_start;
   logic [NUM_REQ-1:0]   op_done;
   logic [NUM_REQ-1:0]   op_tx_start;
   logic [8*NUM_REQ-1:0] op_tx_data;
   logic [NUM_REQ-1:0]   op_tx_busy;
   logic                 tx_busy;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic [NUM_REQ-1:0]   grant;
   logic                 busy;
   logic                 sched_done;
   logic                 stray;
   logic                 timeout;

   modport master (
      output req, op_done, op_tx_start, op_tx_data, tx_busy,
      input  op_start, op_tx_busy, tx_start, tx_data, grant, busy, sched_done, stray, timeout
   );

   modport slave (
      input  req, op_done, op_tx_start, op_tx_data, tx_busy,
      output op_start, op_tx_busy, tx_start, tx_data, grant, busy, sched_done, stray, timeout
   );

endinterface

// File: rtl/op_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from
// last+1 with wrap-around, so the previous winner has lowest priority.
module op_tx_scheduler_rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IW-1:0]      index,
   output logic               any
);

   logic [IW-1:0] k;

   // Scan NUM_REQ positions starting after last; the final position is last itself.
   always_comb begin
      onehot = '0;
      index  = '0;
      any    = 1'b0;
      k      = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         k = IW'((32'(last) + i) % NUM_REQ);
         if (!any && req[k]) begin
            any       = 1'b1;
            index     = k;
            onehot[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/op_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ operation printers. Grants are
// round-robin and held until the winner's done pulse and the UART has drained.
// Optional watchdog: define SCHED_WATCHDOG_EN to release a hung grant after
// WDOG_CYCLES cycles without a forwarded byte.
module op_tx_scheduler
   import op_tx_scheduler_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned WDOG_CYCLES = 100000000
) (
   input logic               clk,
   input logic               rst_n,
   op_tx_scheduler_if.slave  bus
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   sched_state_e       state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] op_start_q, op_start_d;
   // Also serves as the granted index while a grant is held.
   logic [IW-1:0]      last_q, last_d;
   logic               sched_done_q, sched_done_d;
   logic               stray_q, stray_d;
   logic               timeout_q, timeout_d;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [IW-1:0]      pick_index;
   logic               pick_any;
   logic               active;
   logic               wdog_hit;

   assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

   op_tx_scheduler_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr_pick (
      .req    (bus.req),
      .last   (last_q),
      .onehot (pick_onehot),
      .index  (pick_index),
      .any    (pick_any)
   );

   // Route only the granted printer to the UART; everyone else sees busy.
   always_comb begin
      bus.tx_start   = 1'b0;
      bus.tx_data    = 8'h00;
      bus.op_tx_busy = '1;
      if (active) begin
         bus.tx_start           = bus.op_tx_start[last_q];
         bus.tx_data            = bus.op_tx_data[{last_q, 3'b000} +: 8];
         bus.op_tx_busy[last_q] = bus.tx_busy;
      end
   end

`ifdef SCHED_WATCHDOG_EN
   logic [31:0] wdog_q, wdog_d;

   assign wdog_hit = active && (wdog_q == 32'(WDOG_CYCLES - 1));

   // Idle-time counter: restarts outside a grant and on every forwarded byte.
   always_comb begin
      wdog_d = wdog_q + 32'd1;
      if (!active || bus.tx_start) begin
         wdog_d = '0;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   logic unused_wdog;

   assign wdog_hit    = 1'b0;
   assign unused_wdog = ^WDOG_CYCLES;
`endif

   // Next-state logic: arbitrate, wait for done, wait for drain.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_d       = last_q;
      op_start_d   = '0;
      sched_done_d = 1'b0;
      timeout_d    = 1'b0;
      // grant_q is zero when idle, so any strobe there is stray too.
      stray_d      = |(bus.op_tx_start & ~grant_q);
      unique case (state_q)
         S_IDLE: begin
            if (pick_any) begin
               grant_d    = pick_onehot;
               last_d     = pick_index;
               op_start_d = pick_onehot;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.op_done[last_q]) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!bus.tx_busy) begin
               state_d      = S_IDLE;
               grant_d      = '0;
               sched_done_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
      if (wdog_hit) begin
         state_d      = S_IDLE;
         grant_d      = '0;
         sched_done_d = 1'b1;
         timeout_d    = 1'b1;
      end
   end

   // State and registered output pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         op_start_q   <= '0;
         last_q       <= IW'(NUM_REQ - 1);
         sched_done_q <= 1'b0;
         stray_q      <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         op_start_q   <= op_start_d;
         last_q       <= last_d;
         sched_done_q <= sched_done_d;
         stray_q      <= stray_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.grant      = grant_q;
   assign bus.op_start   = op_start_q;
   assign bus.busy       = active;
   assign bus.sched_done = sched_done_q;
   assign bus.stray      = stray_q;
   assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_op_tx_scheduler.sv
// Self-checking bench for op_tx_scheduler: directed scenarios followed by
// random traffic, all compared cycle by cycle against an ownership model.
module tb_op_tx_scheduler;
   import op_tx_scheduler_pkg::*;

   localparam int unsigned N    = 4;
   localparam int unsigned WDOG = 50;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;

   // Reference model: who owns the UART, whether its done has been seen.
   bit          m_act;
   logic [1:0]  m_own;
   logic [1:0]  m_last;
   bit          m_drain;
   int unsigned m_wd;

   logic [7:0] msg [4]    = '{8'h35, 8'h20, 8'h37, 8'h0A};
   logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   op_tx_scheduler_if #(.NUM_REQ(N)) bus ();

   op_tx_scheduler #(
      .NUM_REQ     (N),
      .WDOG_CYCLES (WDOG)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [3:0] own_mask();
      return m_act ? (4'b0001 << m_own) : 4'b0000;
   endfunction

   // Checks routing for the inputs currently driven, advances the model and
   // the DUT by one clock, then checks the registered outputs.
   task automatic tick();
      logic       ets;
      logic [7:0] edata;
      logic [3:0] eotb;
      logic [3:0] mask;
      logic [3:0] n_start;
      logic       n_stray, n_done, n_to, found;
      logic [1:0] k;
      #1;
      mask  = own_mask();
      ets   = 1'b0;
      edata = 8'h00;
      eotb  = 4'b1111;
      if (m_act) begin
         ets         = bus.op_tx_start[m_own];
         edata       = bus.op_tx_data[8*m_own +: 8];
         eotb[m_own] = bus.tx_busy;
      end
      check("tx_start", 8'(bus.tx_start), 8'(ets));
      check("tx_data", bus.tx_data, edata);
      check("op_tx_busy", 8'(bus.op_tx_busy), 8'(eotb));
      n_stray = |(bus.op_tx_start & ~mask);
      n_start = 4'b0000;
      n_done  = 1'b0;
      n_to    = 1'b0;
      if (!m_act) begin
         found = 1'b0;
         for (int d = 1; d <= 4; d++) begin
            k = m_last + 2'(d);
            if (!found && bus.req[k]) begin
               found   = 1'b1;
               m_act   = 1'b1;
               m_own   = k;
               m_last  = k;
               m_drain = 1'b0;
               m_wd    = 0;
               n_start = 4'b0001 << k;
            end
         end
      end else begin
`ifdef SCHED_WATCHDOG_EN
         if (m_wd == WDOG - 1) begin
            m_act  = 1'b0;
            n_done = 1'b1;
            n_to   = 1'b1;
         end else
`endif
         begin
            if (!m_drain) begin
               if (bus.op_done[m_own]) m_drain = 1'b1;
            end else if (!bus.tx_busy) begin
               m_act  = 1'b0;
               n_done = 1'b1;
            end
            m_wd = ets ? 0 : m_wd + 1;
         end
      end
      @(posedge clk);
      #1;
      check("grant", 8'(bus.grant), 8'(own_mask()));
      check("op_start", 8'(bus.op_start), 8'(n_start));
      check("sched_done", 8'(bus.sched_done), 8'(n_done));
      check("stray", 8'(bus.stray), 8'(n_stray));
      check("timeout", 8'(bus.timeout), 8'(n_to));
      check("busy", 8'(bus.busy), 8'(m_act));
   endtask

   // Asserts reset mid-cycle, checks the immediate effect, holds 3 cycles.
   task automatic do_reset();
      rst_n   = 1'b0;
      m_act   = 1'b0;
      m_last  = 2'(N - 1);
      m_drain = 1'b0;
      m_wd    = 0;
      #1;
      check("rst_grant", 8'(bus.grant), 8'h00);
      check("rst_tx_start", 8'(bus.tx_start), 8'h00);
      check("rst_tx_data", bus.tx_data, 8'h00);
      check("rst_op_tx_busy", 8'(bus.op_tx_busy), 8'h0F);
      check("rst_busy", 8'(bus.busy), 8'h00);
      check("rst_op_start", 8'(bus.op_start), 8'h00);
      check("rst_sched_done", 8'(bus.sched_done), 8'h00);
      check("rst_stray", 8'(bus.stray), 8'h00);
      check("rst_timeout", 8'(bus.timeout), 8'h00);
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_grant", 8'(bus.grant), 8'h00);
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(input int maxc);
      int c = 0;
      while (bus.grant == 4'b0000 && c < maxc) begin
         tick();
         c++;
      end
      check("grant_wait", 8'(|bus.grant), 8'h01);
   endtask

   task automatic wait_sched_done(input int maxc);
      int c = 0;
      while (!bus.sched_done && c < maxc) begin
         tick();
         c++;
      end
      check("sched_done_wait", 8'(bus.sched_done), 8'h01);
   endtask

   initial begin
      int c;
      bus.req         = '0;
      bus.op_done     = '0;
      bus.op_tx_start = '0;
      bus.op_tx_data  = '0;
      bus.tx_busy     = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Single request printing "5 7\n", then drain held by tx_busy.
      bus.req = 4'b0001;
      tick();
      check("t1_grant", 8'(bus.grant), 8'h01);
      check("t1_op_start", 8'(bus.op_start), 8'h01);
      tick();
      check("t1_op_start_once", 8'(bus.op_start), 8'h00);
      for (int i = 0; i < 4; i++) begin
         bus.op_tx_start      = 4'b0001;
         bus.op_tx_data[7:0]  = msg[i];
         #1;
         check("t1_byte", bus.tx_data, msg[i]);
         tick();
      end
      bus.op_tx_start = '0;
      bus.tx_busy     = 1'b1;
      bus.op_done     = 4'b0001;
      tick();
      bus.op_done = '0;
      repeat (3) tick();
      check("t1_drain_hold", 8'(bus.grant), 8'h01);
      check("t1_drain_no_done", 8'(bus.sched_done), 8'h00);
      bus.req     = '0;
      bus.tx_busy = 1'b0;
      tick();
      check("t1_release_done", 8'(bus.sched_done), 8'h01);
      check("t1_release_grant", 8'(bus.grant), 8'h00);

      // Round-robin with every request held high.
      do_reset();
      bus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_grant(10);
         check("rr_grant", 8'(bus.grant), 8'(rr_exp[i]));
         bus.op_done = bus.grant;
         tick();
         bus.op_done = '0;
         wait_sched_done(10);
      end
      bus.req = '0;
      tick();

      // Stray strobe from a non-granted printer.
      do_reset();
      bus.req = 4'b0010;
      tick();
      check("stray_grant", 8'(bus.grant), 8'h02);
      bus.op_tx_start          = 4'b0001 << OP_MUL;
      bus.op_tx_data[31:24]    = 8'h41;
      #1;
      check("stray_tx_start", 8'(bus.tx_start), 8'h00);
      check("stray_otb3", 8'(bus.op_tx_busy[OP_MUL]), 8'h01);
      tick();
      bus.op_tx_start = '0;
      check("stray_pulse", 8'(bus.stray), 8'h01);
      tick();
      check("stray_once", 8'(bus.stray), 8'h00);
      check("stray_otb3_after", 8'(bus.op_tx_busy[OP_MUL]), 8'h01);
      bus.op_done = 4'b0010;
      bus.req     = '0;
      tick();
      bus.op_done = '0;
      wait_sched_done(5);

      // Reset in the middle of a grant, then re-grant after release.
      bus.req = 4'b0100;
      tick();
      check("mid_grant", 8'(bus.grant), 8'h04);
      tick();
      bus.op_tx_start = 4'b0100;
      do_reset();
      bus.op_tx_start = '0;
      tick();
      check("mid_regrant", 8'(bus.grant), 8'h04);
      bus.op_done = 4'b0100;
      bus.req     = '0;
      tick();
      bus.op_done = '0;
      wait_sched_done(5);

      // Request dropped while granted does not abort.
      do_reset();
      bus.req = 4'b0010;
      tick();
      check("drop_grant", 8'(bus.grant), 8'h02);
      tick();
      tick();
      bus.req = '0;
      repeat (4) tick();
      check("drop_hold", 8'(bus.grant), 8'h02);
      bus.op_done = 4'b0010;
      tick();
      bus.op_done = '0;
      check("drop_drain_hold", 8'(bus.grant), 8'h02);
      tick();
      check("drop_done", 8'(bus.sched_done), 8'h01);
      check("drop_release", 8'(bus.grant), 8'h00);

      // Printer that never strobes or finishes.
      do_reset();
      bus.req = 4'b0001;
      tick();
      bus.req = '0;
`ifdef SCHED_WATCHDOG_EN
      c = 0;
      while (!bus.timeout && c < 200) begin
         tick();
         c++;
      end
      check("wdog_timeout", 8'(bus.timeout), 8'h01);
      check("wdog_done", 8'(bus.sched_done), 8'h01);
      check("wdog_grant", 8'(bus.grant), 8'h00);
      check("wdog_busy", 8'(bus.busy), 8'h00);
`else
      c = 0;
      repeat (1000) begin
         tick();
         c++;
      end
      check("hang_grant", 8'(bus.grant), 8'h01);
      check("hang_timeout", 8'(bus.timeout), 8'h00);
`endif

      // Random traffic against the model.
      do_reset();
      repeat (400) begin
         if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom_range(0, 15));
         for (int j = 0; j < 4; j++) begin
            bus.op_done[j]     = ($urandom_range(0, 7) == 0);
            bus.op_tx_start[j] = ($urandom_range(0, 3) == 0);
         end
         bus.op_tx_data = 32'($urandom());
         bus.tx_busy    = 1'($urandom_range(0, 1));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
